// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types for the RedMulE Z-buffer scheduler
// Purpose: job configuration, Z-buffer control/flag bundles and scheduler
//          state encoding shared by the scheduler and its neighbours.
package redmule_pkg;

  localparam int unsigned ARRAY_WIDTH = 4;
  localparam int unsigned CFG_W       = 16;

  // Job configuration latched by the scheduler on start.
  typedef struct packed {
    logic [CFG_W-1:0] y_width;
    logic [CFG_W-1:0] y_height;
    logic [CFG_W-1:0] z_width;
    logic [CFG_W-1:0] z_height;
    logic [CFG_W-1:0] n_tiles;
    logic             bias_en;
  } z_sched_cfg_t;

  // Scheduler -> Z-buffer control.
  typedef struct packed {
    logic             y_valid;
    logic             y_push_enable;
    logic             fill;
    logic             ready;
    logic [CFG_W-1:0] y_width;
    logic [CFG_W-1:0] y_height;
    logic [CFG_W-1:0] z_width;
    logic [CFG_W-1:0] z_height;
  } z_buffer_ctrl_t;

  // Z-buffer -> scheduler flags.
  typedef struct packed {
    logic y_ready;
    logic loaded;
    logic y_pushed;
    logic empty;
  } z_buffer_flgs_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_Y,
    PUSH_Y,
    WAIT_FILL,
    STORE,
    DONE
  } z_sched_state_e;

endpackage

// File: rtl/redmule_z_sched.sv
// rtl/redmule_z_sched.sv - Z-buffer job scheduler for RedMulE
// Purpose: sequences one job of n_tiles tiles through optional Y-bias load,
//          Y push into the engine, Z-row fill from the engine and Z store.
// Ports:
//   clk_i, rst_i (sync, active-high), clear_i (soft clear), start_i, cfg_i
//   y_stream_valid_i / y_stream_ready_o    : Y-load handshake
//   engine_z_valid_i / engine_z_ready_o    : engine result-row handshake
//   engine_ready_i, z_stream_ready_i       : engine / Z-store sink readiness
//   buf_flags_i, buf_ctrl_o, buf_clear_o   : Z-buffer interface
//   busy_o, done_o, tile_o                 : status
// Optional: REDMULE_ZSCHED_PERF_EN adds stall_y_o / stall_z_o stall counters.
module redmule_z_sched
  import redmule_pkg::*;
#(
  parameter int unsigned Width = ARRAY_WIDTH,
  parameter int unsigned Depth = 16,
  parameter int unsigned TileW = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clear_i,
  input  logic           start_i,
  input  z_sched_cfg_t   cfg_i,
  input  logic           y_stream_valid_i,
  output logic           y_stream_ready_o,
  input  logic           engine_z_valid_i,
  output logic           engine_z_ready_o,
  input  logic           engine_ready_i,
  input  logic           z_stream_ready_i,
  input  z_buffer_flgs_t buf_flags_i,
  output z_buffer_ctrl_t buf_ctrl_o,
  output logic           buf_clear_o,
  output logic           busy_o,
  output logic           done_o,
  output logic [TileW-1:0] tile_o
`ifdef REDMULE_ZSCHED_PERF_EN
  ,
  output logic [31:0]    stall_y_o,
  output logic [31:0]    stall_z_o
`endif
);

  // A tile never holds more rows than the larger buffer dimension.
  localparam int unsigned RowMax = (Width > Depth) ? Width : Depth;
  localparam int unsigned CntW   = $clog2(RowMax) + 1;

  z_sched_state_e   state_q, state_d;
  z_sched_cfg_t     cfg_q, cfg_d;
  logic [CntW-1:0]  fill_cnt_q, fill_cnt_d;
  logic [TileW-1:0] tile_q, tile_d;

  logic             clr;
  logic             fill;
  logic             last_fill;
  logic             last_tile;
  logic [CFG_W-1:0] tiles_m1;

`ifdef REDMULE_ZSCHED_PERF_EN
  logic [31:0] stall_y_q, stall_y_d;
  logic [31:0] stall_z_q, stall_z_d;
`endif

  assign clr       = rst_i | clear_i;
  assign last_fill = (CFG_W'(fill_cnt_q) == (cfg_q.z_height - CFG_W'(1)));
  // A zero tile count behaves as a single tile.
  assign tiles_m1  = (cfg_q.n_tiles == '0) ? '0 : (cfg_q.n_tiles - CFG_W'(1));
  assign last_tile = (tile_q == TileW'(tiles_m1));

  always_comb begin
    state_d          = state_q;
    cfg_d            = cfg_q;
    fill_cnt_d       = fill_cnt_q;
    tile_d           = tile_q;
    buf_ctrl_o       = '0;
    y_stream_ready_o = 1'b0;
    engine_z_ready_o = 1'b0;
    done_o           = 1'b0;
    busy_o           = (state_q != IDLE);

    buf_ctrl_o.y_width  = cfg_q.y_width;
    buf_ctrl_o.y_height = cfg_q.y_height;
    buf_ctrl_o.z_width  = cfg_q.z_width;
    buf_ctrl_o.z_height = cfg_q.z_height;

    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d      = cfg_i;
          fill_cnt_d = '0;
          tile_d     = '0;
          state_d    = cfg_i.bias_en ? LOAD_Y : WAIT_FILL;
        end
      end
      LOAD_Y: begin
        buf_ctrl_o.y_valid = y_stream_valid_i;
        y_stream_ready_o   = buf_flags_i.y_ready;
        if (buf_flags_i.loaded) state_d = PUSH_Y;
      end
      PUSH_Y: begin
        buf_ctrl_o.y_push_enable = engine_ready_i;
        engine_z_ready_o         = 1'b1;
        if (buf_flags_i.y_pushed) state_d = WAIT_FILL;
      end
      WAIT_FILL: begin
        engine_z_ready_o = 1'b1;
      end
      STORE: begin
        buf_ctrl_o.ready = z_stream_ready_i;
        if (buf_flags_i.empty) begin
          if (last_tile) begin
            state_d = DONE;
          end else begin
            tile_d  = tile_q + 1'b1;
            state_d = cfg_q.bias_en ? LOAD_Y : WAIT_FILL;
          end
        end
      end
      DONE: begin
        done_o  = 1'b1;
        tile_d  = '0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // The final row of a tile wins over a pending Y push: the push is dropped.
    fill            = engine_z_valid_i & engine_z_ready_o;
    buf_ctrl_o.fill = fill;
    if (fill) begin
      if (last_fill) begin
        fill_cnt_d = '0;
        state_d    = STORE;
      end else begin
        fill_cnt_d = fill_cnt_q + 1'b1;
      end
    end

    if (clr) begin
      buf_ctrl_o       = '0;
      y_stream_ready_o = 1'b0;
      engine_z_ready_o = 1'b0;
      done_o           = 1'b0;
      busy_o           = 1'b0;
    end
  end

`ifdef REDMULE_ZSCHED_PERF_EN
  always_comb begin
    stall_y_d = stall_y_q;
    stall_z_d = stall_z_q;
    if (state_q == IDLE && start_i) begin
      stall_y_d = '0;
      stall_z_d = '0;
    end else begin
      if (state_q == LOAD_Y && !y_stream_valid_i) stall_y_d = stall_y_q + 32'd1;
      if (state_q == STORE && !z_stream_ready_i)  stall_z_d = stall_z_q + 32'd1;
    end
  end

  assign stall_y_o = clr ? '0 : stall_y_q;
  assign stall_z_o = clr ? '0 : stall_z_q;
`endif

  assign buf_clear_o = clr;
  assign tile_o      = clr ? '0 : tile_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      cfg_q      <= '0;
      fill_cnt_q <= '0;
      tile_q     <= '0;
`ifdef REDMULE_ZSCHED_PERF_EN
      stall_y_q  <= '0;
      stall_z_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cfg_q      <= cfg_d;
      fill_cnt_q <= fill_cnt_d;
      tile_q     <= tile_d;
`ifdef REDMULE_ZSCHED_PERF_EN
      stall_y_q  <= stall_y_d;
      stall_z_q  <= stall_z_d;
`endif
    end
  end

endmodule

// File: doc/redmule_z_sched.md
REDMULE_Z_SCHED -- requirements
Module: redmule_z_sched

Interface
REQ-001 SHALL have parameter Width, default ARRAY_WIDTH, meaning Z-buffer columns (W).
REQ-002 SHALL have parameter Depth, default 16, meaning Z-buffer rows (D).
REQ-003 SHALL have parameter TileW, default 16, meaning tile-counter width.
REQ-004 SHALL have port clk_i  in  1  clock; one clock only.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port clear_i  in  1  soft clear.
REQ-007 SHALL have port start_i  in  1  job start pulse.
REQ-008 SHALL have port cfg_i  in  z_sched_cfg_t  fields y_width, y_height, z_width, z_height, n_tiles, bias_en.
REQ-009 SHALL have port y_stream_valid_i / y_stream_ready_o  in/out  1  Y-load handshake.
REQ-010 SHALL have port engine_z_valid_i / engine_z_ready_o  in/out  1  engine result-row handshake.
REQ-011 SHALL have port engine_ready_i  in  1  engine accepts a Y push.
REQ-012 SHALL have port z_stream_ready_i  in  1  Z-store sink ready.
REQ-013 SHALL have port buf_flags_i  in  z_buffer_flgs_t  Z-buffer flags.
REQ-014 SHALL have port buf_ctrl_o  out  z_buffer_ctrl_t  Z-buffer control.
REQ-015 SHALL have port buf_clear_o  out  1  Z-buffer clear.
REQ-016 SHALL have port busy_o, done_o  out  1 each  status outputs.
REQ-017 SHALL have port tile_o  out  TileW  current tile index.

Function
REQ-018 SHALL implement FSM states IDLE, LOAD_Y, PUSH_Y, WAIT_FILL, STORE, DONE.
REQ-019 IDLE SHALL go to LOAD_Y on start_i when bias_en=1, else to WAIT_FILL; cfg_i SHALL be registered on start.
REQ-020 start_i outside IDLE SHALL be ignored.
REQ-021 LOAD_Y: buf_ctrl_o.y_valid = y_stream_valid_i; y_stream_ready_o = buf_flags_i.y_ready; go to PUSH_Y when buf_flags_i.loaded.
REQ-022 PUSH_Y: buf_ctrl_o.y_push_enable = engine_ready_i; go to WAIT_FILL on buf_flags_i.y_pushed.
REQ-023 engine_z_ready_o SHALL be 1 only in PUSH_Y and WAIT_FILL; buf_ctrl_o.fill = engine_z_valid_i & engine_z_ready_o.
REQ-024 fill_cnt SHALL count fills; on the fill with fill_cnt==z_height-1 it SHALL reset to 0 and the FSM SHALL go to STORE, also from PUSH_Y (an unfinished Y push is abandoned).
REQ-025 STORE: buf_ctrl_o.ready = z_stream_ready_i; on buf_flags_i.empty, if tile_o==n_tiles-1 go to DONE, else increment tile_o and re-enter LOAD_Y/WAIT_FILL per bias_en.
REQ-026 DONE SHALL last one cycle with done_o=1, then go to IDLE with tile_o=0.
REQ-027 busy_o SHALL be 1 in all states except IDLE.
REQ-028 buf_ctrl_o size fields SHALL be driven from registered cfg at all times.
REQ-029 n_tiles=0 SHALL be treated as 1.
REQ-030 y_push_enable and fill SHALL be allowed in the same cycle.
REQ-031 All handshake outputs SHALL be 0 in IDLE and DONE.

Reset
REQ-032 rst_i or clear_i SHALL force IDLE, zero all counters and cfg, set all outputs to 0, and assert buf_clear_o for exactly that cycle, mid-job included.

Configuration
REQ-033 With REDMULE_ZSCHED_PERF_EN defined, the block SHALL add 32-bit outputs stall_y_o (LOAD_Y with y_stream_valid_i=0) and stall_z_o (STORE with z_stream_ready_i=0), both cleared on start_i; without the macro these ports and counters SHALL be absent.

Structure
REQ-034 z_sched_cfg_t and the state enum SHALL live in redmule_pkg; z_buffer_ctrl_t and z_buffer_flgs_t SHALL be reused from there.
REQ-035 The block SHALL be single-module with no sub-module; the FSM and counters SHALL be inline.

Verification
REQ-036 Test bias_en=1, n_tiles=1, W=D=4: Y loads 4 rows, pushes 4, fills 4, stores 4 -> DONE, done_o one cycle, busy_o falls next cycle.
REQ-037 Test bias_en=0, n_tiles=3: never enters LOAD_Y, tile_o steps 0,1,2, done_o after the third empty.
REQ-038 Test z_stream_ready_i=0 for 10 cycles in STORE: state held, buf_ctrl_o.ready=0; with PERF_EN, stall_z_o=10.
REQ-039 Test z_height=1 fill arriving in PUSH_Y -> next state STORE, y_push_enable stops.
REQ-040 Test clear_i during WAIT_FILL with fill_cnt=2 -> IDLE, fill_cnt=0, buf_clear_o pulsed; a new start works.
REQ-041 Test start_i during STORE -> ignored, tile_o unchanged.
